ahb_bus_arbiter: RTL

Multi-master AHB bus arbiter for the forward-transform SoC. It shares the single AHB address/data bus (decoder, slave mux, SRAM/SDRAM controllers, accelerator shell) among up to `NUM_MASTERS` requesters, such as the CPU and a DMA engine. It drives grant and current-master signals, never breaks a fixed-length burst or a locked sequence, and parks the bus on master 0 when no one requests.

---
 rtl/ahb_arb_pkg.sv | 38 +++
 rtl/ahb_arb_picker.sv | 35 +++
 rtl/ahb_bus_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/ahb_arb_pkg.sv
// rtl/ahb_arb_pkg.sv - AHB encodings, burst lengths and arbiter state type
package ahb_arb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic [2:0] HBURST_SINGLE = 3'd0;
   localparam logic [2:0] HBURST_INCR   = 3'd1;
   localparam logic [2:0] HBURST_WRAP4  = 3'd2;
   localparam logic [2:0] HBURST_INCR4  = 3'd3;
   localparam logic [2:0] HBURST_WRAP8  = 3'd4;
   localparam logic [2:0] HBURST_INCR8  = 3'd5;
   localparam logic [2:0] HBURST_WRAP16 = 3'd6;
   localparam logic [2:0] HBURST_INCR16 = 3'd7;

   localparam logic [3:0] BEATS4_M1  = 4'd3;
   localparam logic [3:0] BEATS8_M1  = 4'd7;
   localparam logic [3:0] BEATS16_M1 = 4'd15;

   typedef enum logic [1:0] {
      ARB    = 2'd0,
      BURST  = 2'd1,
      LOCKED = 2'd2
   } arb_state_t;

   // Beats still to come after the NONSEQ; zero for undefined-length bursts.
   function automatic logic [3:0] burst_len_m1(input logic [2:0] hburst);
      case (hburst)
         HBURST_WRAP4,  HBURST_INCR4:  return BEATS4_M1;
         HBURST_WRAP8,  HBURST_INCR8:  return BEATS8_M1;
         HBURST_WRAP16, HBURST_INCR16: return BEATS16_M1;
         default:                      return 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/ahb_arb_picker.sv
// rtl/ahb_arb_picker.sv - one-hot winner search over requests from a start index
module ahb_arb_picker
   import ahb_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 4,
   parameter int MASTER_W    = 2
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [MASTER_W-1:0]    start,
   output logic [NUM_MASTERS-1:0] winner,
   output logic                   valid
);

   logic [MASTER_W:0]   sum;
   logic [MASTER_W-1:0] idx;

   // start < NUM_MASTERS, so one conditional subtract gives the modulo.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      sum    = '0;
      idx    = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         sum = {1'b0, start} + (MASTER_W+1)'(i);
         if (sum >= (MASTER_W+1)'(NUM_MASTERS))
            sum = sum - (MASTER_W+1)'(NUM_MASTERS);
         idx = sum[MASTER_W-1:0];
         if (!valid && req[idx]) begin
            winner[idx] = 1'b1;
            valid       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// rtl/ahb_bus_arbiter.sv - AHB multi-master arbiter; AHB_ARB_ROUND_ROBIN_EN selects round-robin
module ahb_bus_arbiter
   import ahb_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 4,
   parameter int MASTER_W    = 2
) (
   input  logic                   in_HCLK,
   input  logic                   in_HRESET,
   input  logic [NUM_MASTERS-1:0] in_HBUSREQ,
   input  logic [NUM_MASTERS-1:0] in_HLOCK,
   input  logic [1:0]             in_HTRANS,
   input  logic [2:0]             in_HBURST,
   input  logic                   in_HREADY,
   output logic [NUM_MASTERS-1:0] out_HGRANT,
   output logic [MASTER_W-1:0]    out_HMASTER,
   output logic                   out_HMASTLOCK
);

   localparam logic [NUM_MASTERS-1:0] PARK = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

   logic [NUM_MASTERS-1:0] grant_q, grant_nxt, pick_gnt;
   logic                   pick_valid;
   logic [MASTER_W-1:0]    owner_idx, start_idx, hmaster_q;
   logic                   hmastlock_q, lock_req, rearb;
   logic [3:0]             cnt_q, cnt_nxt;
   arb_state_t             state_q, state_nxt;

   function automatic logic [MASTER_W-1:0] onehot_to_idx(input logic [NUM_MASTERS-1:0] oh);
      logic [MASTER_W-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_MASTERS; i++)
         if (oh[i]) r = MASTER_W'(i);
      return r;
   endfunction

`ifdef AHB_ARB_ROUND_ROBIN_EN
   logic [MASTER_W-1:0] ptr_q;
   assign start_idx = (ptr_q == MASTER_W'(NUM_MASTERS - 1)) ? '0 : ptr_q + MASTER_W'(1);
`else
   assign start_idx = '0;
`endif

   ahb_arb_picker #(
      .NUM_MASTERS (NUM_MASTERS),
      .MASTER_W    (MASTER_W)
   ) u_picker (
      .req    (in_HBUSREQ),
      .start  (start_idx),
      .winner (pick_gnt),
      .valid  (pick_valid)
   );

   // Grant only moves when the edge leaves both the lock and any fixed-length burst behind.
   always_comb begin
      owner_idx = onehot_to_idx(grant_q);
      lock_req  = in_HLOCK[owner_idx];
      cnt_nxt   = cnt_q;
      case (in_HTRANS)
         HTRANS_NONSEQ: cnt_nxt = burst_len_m1(in_HBURST);
         HTRANS_SEQ:    if (cnt_q != 4'd0) cnt_nxt = cnt_q - 4'd1;
         HTRANS_IDLE:   if (state_q == BURST) cnt_nxt = 4'd0;
         HTRANS_BUSY:   ;
      endcase
      if (lock_req)
         state_nxt = LOCKED;
      else if (cnt_nxt != 4'd0)
         state_nxt = BURST;
      else
         state_nxt = ARB;
      rearb     = (state_nxt == ARB);
      grant_nxt = grant_q;
      if (rearb)
         grant_nxt = pick_valid ? pick_gnt : PARK;
   end

   always_ff @(posedge in_HCLK) begin
      if (!in_HRESET) begin
         grant_q     <= PARK;
         hmaster_q   <= '0;
         hmastlock_q <= 1'b0;
         cnt_q       <= '0;
         state_q     <= ARB;
`ifdef AHB_ARB_ROUND_ROBIN_EN
         ptr_q       <= '0;
`endif
      end else if (in_HREADY) begin
         grant_q     <= grant_nxt;
         hmaster_q   <= owner_idx;
         hmastlock_q <= lock_req;
         cnt_q       <= cnt_nxt;
         state_q     <= state_nxt;
`ifdef AHB_ARB_ROUND_ROBIN_EN
         if (rearb && pick_valid && (pick_gnt != grant_q))
            ptr_q <= onehot_to_idx(pick_gnt);
`endif
      end
   end

   assign out_HGRANT    = grant_q;
   assign out_HMASTER   = hmaster_q;
   assign out_HMASTLOCK = hmastlock_q;

endmodule
